// File: rtl/alu_seq_unit.sv
// alu_seq_unit: execute-stage ALU with ALU-control decode, registered result
// under a valid/ready handshake, and an optional iterative unsigned multiplier.
// Build option: define ALU_MULTU_EN to include the MULTU shift-add engine
// (func 0x19). Without it, func 0x19 decodes as illegal and o_hi is tied to 0.
module alu_seq_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_aluOp,
  input  logic [5:0]         i_func,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [WIDTH-1:0]   o_result,
  output logic [WIDTH-1:0]   o_hi,
  output logic               o_zero,
  output logic               o_valid,
  output logic               o_illegal,
  output logic [3:0]         o_aluControl
);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SLTU = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLL  = 4'b1000;
  localparam logic [3:0] CTRL_SRA  = 4'b1001;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_ILL  = 4'b1110;
  localparam logic [3:0] CTRL_SRL  = 4'b1111;
`ifdef ALU_MULTU_EN
  localparam logic [3:0] CTRL_MULTU = 4'b1010;
`endif

  logic [3:0]       dec_ctrl;
  logic             dec_illegal;
  logic [WIDTH-1:0] alu_res;
  logic             accept;

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       ctrl_q, ctrl_d;

`ifdef ALU_MULTU_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial high, shifting multiplier/low}
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic               dec_is_mul;

  assign o_ready    = (state_q == ST_IDLE);
  assign o_hi       = hi_q;
  assign dec_is_mul = (dec_ctrl == CTRL_MULTU);
`else
  assign o_ready = 1'b1;
  assign o_hi    = '0;
`endif

  assign accept       = i_valid && o_ready;
  assign o_result     = result_q;
  assign o_zero       = zero_q;
  assign o_valid      = valid_q;
  assign o_illegal    = illegal_q;
  assign o_aluControl = ctrl_q;

  // ALU-control decode from op class and func field
  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    case (i_aluOp)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b11: dec_ctrl = CTRL_SLT;
      default: begin
        case (i_func)
          6'h20: dec_ctrl = CTRL_ADD;
          6'h22: dec_ctrl = CTRL_SUB;
          6'h24: dec_ctrl = CTRL_AND;
          6'h25: dec_ctrl = CTRL_OR;
          6'h26: dec_ctrl = CTRL_XOR;
          6'h27: dec_ctrl = CTRL_NOR;
          6'h2A: dec_ctrl = CTRL_SLT;
          6'h2B: dec_ctrl = CTRL_SLTU;
          6'h00: dec_ctrl = CTRL_SLL;
          6'h02: dec_ctrl = CTRL_SRL;
          6'h03: dec_ctrl = CTRL_SRA;
`ifdef ALU_MULTU_EN
          6'h19: dec_ctrl = CTRL_MULTU;
`endif
          default: begin
            dec_ctrl    = CTRL_ILL;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Single-cycle datapath; shifts act on operand a, illegal yields zero
  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      CTRL_ADD:  alu_res = i_a + i_b;
      CTRL_SUB:  alu_res = i_a - i_b;
      CTRL_AND:  alu_res = i_a & i_b;
      CTRL_OR:   alu_res = i_a | i_b;
      CTRL_XOR:  alu_res = i_a ^ i_b;
      CTRL_NOR:  alu_res = ~(i_a | i_b);
      CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      CTRL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      CTRL_SLL:  alu_res = i_a << i_shamt;
      CTRL_SRL:  alu_res = i_a >> i_shamt;
      CTRL_SRA:  alu_res = $unsigned($signed(i_a) >>> i_shamt);
      default:   alu_res = '0;
    endcase
  end

  // Next-state: accept handling, multiplier iteration and result capture
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;
    valid_d   = 1'b0;
`ifdef ALU_MULTU_EN
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    // Add multiplicand into the high half when the current multiplier bit
    // (acc LSB) is set, then shift the whole accumulator right by one.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    if (accept) begin
      ctrl_d = dec_ctrl;
`ifdef ALU_MULTU_EN
      if (dec_is_mul) begin
        state_d = ST_MUL;
        acc_d   = {{WIDTH{1'b0}}, i_b};
        mcand_d = i_a;
        cnt_d   = '0;
      end else
`endif
      begin
        valid_d   = 1'b1;
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        illegal_d = dec_illegal;
      end
    end

`ifdef ALU_MULTU_EN
    // o_ready is low in MUL, so this never overlaps an accept
    if (state_q == ST_MUL) begin
      acc_d = acc_step;
      cnt_d = cnt_q + SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(WIDTH-1)) begin
        state_d   = ST_IDLE;
        valid_d   = 1'b1;
        result_d  = acc_step[WIDTH-1:0];
        hi_d      = acc_step[2*WIDTH-1:WIDTH];
        zero_d    = (acc_step[WIDTH-1:0] == '0);
        illegal_d = 1'b0;
      end
    end
`endif
  end

  // State and output registers with synchronous reset (also aborts MULTU)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= 4'b0000;
`ifdef ALU_MULTU_EN
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
`endif
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
`ifdef ALU_MULTU_EN
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Testbench for alu_seq_unit (WIDTH=32): directed steps from the test plan
// followed by randomized ops, all checked against a behavioural model.
// MULTU paths are exercised when ALU_MULTU_EN is defined; otherwise func 0x19
// is expected to come back illegal in one cycle.
module tb_alu_seq_unit;
  localparam int W = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_aluOp;
  logic [5:0]    i_func;
  logic [W-1:0]  i_a, i_b;
  logic [4:0]    i_shamt;
  logic [W-1:0]  o_result, o_hi;
  logic          o_zero, o_valid, o_illegal;
  logic [3:0]    o_aluControl;

  int checks   = 0;
  int failures = 0;

  // expected architectural state tracked by the bench
  logic [W-1:0] exp_hi   = '0;
  logic [W-1:0] last_res = '0;
  logic         last_zero = 1'b0;
  logic         last_ill  = 1'b0;
  logic [3:0]   last_ctrl = 4'b0000;

  alu_seq_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_aluOp(i_aluOp), .i_func(i_func), .i_a(i_a), .i_b(i_b), .i_shamt(i_shamt),
    .o_result(o_result), .o_hi(o_hi), .o_zero(o_zero), .o_valid(o_valid),
    .o_illegal(o_illegal), .o_aluControl(o_aluControl)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: what the op means, straight from the op tables
  task automatic model(input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh,
                       output logic [W-1:0] res, output logic [3:0] ctrl,
                       output logic ill, output logic mul);
    ill = 1'b0; mul = 1'b0; res = '0; ctrl = 4'b1110;
    if (op == 2'b00)      begin res = a + b; ctrl = 4'b0010; end
    else if (op == 2'b01) begin res = a - b; ctrl = 4'b0110; end
    else if (op == 2'b11) begin res = ($signed(a) < $signed(b)) ? 1 : 0; ctrl = 4'b0111; end
    else begin
      case (fn)
        6'h20: begin res = a + b;    ctrl = 4'b0010; end
        6'h22: begin res = a - b;    ctrl = 4'b0110; end
        6'h24: begin res = a & b;    ctrl = 4'b0000; end
        6'h25: begin res = a | b;    ctrl = 4'b0001; end
        6'h26: begin res = a ^ b;    ctrl = 4'b0011; end
        6'h27: begin res = ~(a | b); ctrl = 4'b1100; end
        6'h2A: begin res = ($signed(a) < $signed(b)) ? 1 : 0; ctrl = 4'b0111; end
        6'h2B: begin res = (a < b) ? 1 : 0; ctrl = 4'b0101; end
        6'h00: begin res = a << sh;  ctrl = 4'b1000; end
        6'h02: begin res = a >> sh;  ctrl = 4'b1111; end
        6'h03: begin res = $unsigned($signed(a) >>> sh); ctrl = 4'b1001; end
`ifdef ALU_MULTU_EN
        6'h19: begin mul = 1'b1; ctrl = 4'b1010; end
`endif
        default: begin ill = 1'b1; res = '0; ctrl = 4'b1110; end
      endcase
    end
  endtask

  // Present one request, then check its result at the right cycle.
  // Called #1 after a rising edge; returns #1 after the result edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
    logic [W-1:0] res;
    logic [3:0]   ctrl;
    logic         ill, mul;
    logic [63:0]  prod;
    model(op, fn, a, b, sh, res, ctrl, ill, mul);
    check({tag, ".ready_in"}, {63'd0, o_ready}, 64'd1);
    i_aluOp = op; i_func = fn; i_a = a; i_b = b; i_shamt = sh; i_valid = 1'b1;
    @(posedge i_clk); #1;
    if (!mul) begin
      i_valid = 1'b0;
      last_res = res; last_zero = (res == '0); last_ill = ill; last_ctrl = ctrl;
    end else begin
      prod = {32'd0, a} * {32'd0, b};
      check({tag, ".ctrl_mul"}, {60'd0, o_aluControl}, {60'd0, ctrl});
      // a competing ADD that must be ignored while busy
      i_aluOp = 2'b00; i_a = $urandom; i_b = $urandom; i_valid = 1'b1;
      for (int c = 1; c <= W; c++) begin
        if (o_ready !== 1'b0 || o_valid !== 1'b0)
          check($sformatf("%s.busy%0d", tag, c), {62'd0, o_ready, o_valid}, 64'd0);
        @(posedge i_clk); #1;
      end
      checks++;  // the busy window as one aggregate comparison
      i_valid = 1'b0;
      exp_hi = prod[63:32];
      last_res = prod[31:0]; last_zero = (prod[31:0] == '0); last_ill = 1'b0; last_ctrl = ctrl;
    end
    check({tag, ".valid"},   {63'd0, o_valid},   64'd1);
    check({tag, ".result"},  {32'd0, o_result},  {32'd0, last_res});
    check({tag, ".zero"},    {63'd0, o_zero},    {63'd0, last_zero});
    check({tag, ".illegal"}, {63'd0, o_illegal}, {63'd0, last_ill});
    check({tag, ".ctrl"},    {60'd0, o_aluControl}, {60'd0, last_ctrl});
    check({tag, ".hi"},      {32'd0, o_hi},      {32'd0, exp_hi});
    $display("op %-14s aluOp=%b func=%02h a=%08h b=%08h sh=%0d -> res=%08h hi=%08h zero=%b ill=%b ctrl=%b",
             tag, op, fn, a, b, sh, o_result, o_hi, o_zero, o_illegal, o_aluControl);
  endtask

  // One cycle with no request: strobe drops, result registers hold
  task automatic idle_check(input string tag);
    @(posedge i_clk); #1;
    check({tag, ".valid"},  {63'd0, o_valid},  64'd0);
    check({tag, ".hold"},   {32'd0, o_result}, {32'd0, last_res});
    check({tag, ".zhold"},  {63'd0, o_zero},   {63'd0, last_zero});
    check({tag, ".ready"},  {63'd0, o_ready},  64'd1);
  endtask

  logic [5:0] fn_tab [14];

  initial begin
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
               6'h2B, 6'h00, 6'h02, 6'h03, 6'h19, 6'h3F, 6'h01};
    i_rst = 1'b1; i_valid = 1'b0; i_aluOp = '0; i_func = '0;
    i_a = '0; i_b = '0; i_shamt = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst.result", {32'd0, o_result}, 64'd0);
    check("rst.hi",     {32'd0, o_hi},     64'd0);
    check("rst.zero",   {63'd0, o_zero},   64'd0);
    check("rst.valid",  {63'd0, o_valid},  64'd0);
    check("rst.illegal",{63'd0, o_illegal},64'd0);
    check("rst.ctrl",   {60'd0, o_aluControl}, 64'd0);
    i_rst = 1'b0;
    check("rst.ready",  {63'd0, o_ready},  64'd1);

    // directed steps
    run_op("add",     2'b10, 6'h20, 32'd5, 32'd7, 5'd0);
    run_op("sub_beq", 2'b01, 6'h00, 32'h1234, 32'h1234, 5'd0);
    run_op("slt",     2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0);
    run_op("sltu",    2'b10, 6'h2B, 32'hFFFFFFFF, 32'd1, 5'd0);
    run_op("sra",     2'b10, 6'h03, 32'h80000000, 32'd1, 5'd4);
    run_op("srl",     2'b10, 6'h02, 32'h80000000, 32'd1, 5'd4);
    idle_check("idle1");
    run_op("illegal", 2'b10, 6'h3F, 32'hDEADBEEF, 32'h1, 5'd3);
    run_op("multu",   2'b10, 6'h19, 32'hFFFFFFFF, 32'd2, 5'd0);
    run_op("add_post",2'b10, 6'h20, 32'd1, 32'd1, 5'd0);
    run_op("slti",    2'b11, 6'h00, 32'd3, 32'hFFFFFFFE, 5'd0);
    run_op("lw_add",  2'b00, 6'h3F, 32'h7FFFFFFF, 32'd1, 5'd0);
    idle_check("idle2");

    // randomized ops
    for (int n = 0; n < 150; n++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) op = 2'b10;
      fn = fn_tab[$urandom_range(0, 13)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      run_op($sformatf("rnd%0d", n), op, fn, $urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 4) == 0) idle_check($sformatf("rnd_idle%0d", n));
    end

`ifdef ALU_MULTU_EN
    // make o_hi non-zero, then abort a MULTU with reset at iteration 10
    run_op("mul_pre", 2'b10, 6'h19, 32'hFFFFFFFF, 32'd2, 5'd0);
    i_aluOp = 2'b10; i_func = 6'h19; i_a = 32'h12345678; i_b = 32'h9ABCDEF1; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    check("abort.busy", {63'd0, o_ready}, 64'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("abort.valid", {63'd0, o_valid}, 64'd0);
    check("abort.hi",    {32'd0, o_hi},    64'd0);
    check("abort.result",{32'd0, o_result},64'd0);
    check("abort.ctrl",  {60'd0, o_aluControl}, 64'd0);
    check("abort.ready", {63'd0, o_ready}, 64'd1);
    exp_hi = '0; last_res = '0; last_zero = 1'b0; last_ill = 1'b0; last_ctrl = 4'b0000;
    for (int c = 0; c < W + 4; c++) begin
      @(posedge i_clk); #1;
      if (o_valid !== 1'b0) check($sformatf("abort.late%0d", c), {63'd0, o_valid}, 64'd0);
    end
    checks++;
    $display("op abort         reset at iteration 10 -> ready=%b hi=%08h", o_ready, o_hi);
    run_op("add_after_abort", 2'b10, 6'h20, 32'd9, 32'd1, 5'd0);
`else
    run_op("multu_off", 2'b10, 6'h19, 32'h5, 32'h6, 5'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised execute-stage ALU that merges ALU-control decoding with registered execution and an optional iterative unsigned multiplier. Takes the main decoder's `i_aluOp` and the instruction `func` field with operands, and returns a registered result under a valid/ready handshake. Sits between the register-file read stage and writeback/branch logic. Extends the MIPS op set with XOR, SLTU, SRA, SLTI and MULTU.

## Interface
- `WIDTH`, 32: operand/result width (≥ 8).
- `SHAMT_W`, 5: shift-amount width, equal to clog2(WIDTH).

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  operation request.
- `o_ready`  out  1  unit accepts a request this cycle.
- `i_aluOp`  in  2  main-decoder ALU op class.
- `i_func`  in  6  R-type func field.
- `i_a`, `i_b`  in  WIDTH  operands.
- `i_shamt`  in  SHAMT_W  shift amount.
- `o_result`  out  WIDTH  registered result (MULTU: low word).
- `o_hi`  out  WIDTH  MULTU high word.
- `o_zero`  out  1  `o_result` == 0.
- `o_valid`  out  1  one-cycle result strobe.
- `o_illegal`  out  1  undefined func; valid only with `o_valid`.
- `o_aluControl`  out  4  registered decoded control code of the last accepted op.

## Operation
- Accept occurs when `i_valid && o_ready`. Operands, shamt and decoded code are captured at the accept edge.
- `o_ready` is high exactly when the state is IDLE.
- **Decode for `i_aluOp`:**
  - 00 → ADD 0010 (lw/sw).
  - 01 → SUB 0110 (beq).
  - 11 → SLT 0111 (slti).
  - 10 → decode `i_func`:
    - 0x20 ADD 0010
    - 0x22 SUB 0110
    - 0x24 AND 0000
    - 0x25 OR 0001
    - 0x26 XOR 0011
    - 0x27 NOR 1100
    - 0x2A SLT 0111
    - 0x2B SLTU 0101
    - 0x00 SLL 1000
    - 0x02 SRL 1111
    - 0x03 SRA 1001
    - 0x19 MULTU 1010
- **Illegal func:** any other func sets `o_illegal`=1, `o_result`=0, `o_aluControl`=1110. The op takes the single-cycle path.
- **Arithmetic:**
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is a signed compare; SLTU is unsigned. Both produce 1 or 0, zero-extended.
  - Shifts use `i_shamt` only; SRA replicates bit WIDTH-1.
- **States:**
  - IDLE: on accepting a single-cycle op, stay in IDLE. On accepting MULTU, go to MUL.
  - MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator, iteration counter 0..WIDTH-1. After iteration WIDTH-1, return to IDLE.
- **Result registers:**
  - `o_result`, `o_zero` and `o_illegal` update only when `o_valid` is raised, and hold otherwise.
  - `o_hi` updates only on MULTU completion and is unaffected by other ops.
- While `o_ready`=0, `i_valid` is ignored. No queuing: the request is lost unless the source holds it.

## Timing
- Reset values: `o_result`=0, `o_hi`=0, `o_zero`=0, `o_valid`=0, `o_illegal`=0, `o_aluControl`=0000, state IDLE. `o_ready`=1 in the first cycle after reset deasserts.
- **Single-cycle op:** accept at edge k → `o_valid`=1 for one cycle after edge k. Back-to-back accepts give one result per cycle.
- **MULTU:**
  - Accept at edge k → `o_ready`=0 from edge k.
  - `o_valid`=1 and `o_ready`=1 after edge k+WIDTH.
  - A new request may be accepted in that same cycle.
- **Reset mid-MULTU:** aborts immediately. No `o_valid` is produced, all outputs return to reset values, and `o_ready`=1 in the next cycle.
- `o_zero` is registered together with `o_result`. It is never combinational from the inputs.

## Configuration
- `ALU_MULTU_EN` defined: MUL state, accumulator and counter are built; func 0x19 executes MULTU as above.
- `ALU_MULTU_EN` undefined:
  - func 0x19 is illegal and takes the single-cycle path.
  - `o_hi` is tied to 0.
  - `o_ready` is constant 1 outside reset.

## Test plan
- ADD, `i_aluOp`=10, func 0x20, a=5, b=7 → one cycle later `o_valid`=1, `o_result`=12, `o_zero`=0, `o_aluControl`=0010.
- SUB, `i_aluOp`=01, a=b=0x1234 → `o_result`=0, `o_zero`=1, `o_aluControl`=0110.
- Compare and shift, a=0xFFFFFFFF, b=1:
  - SLT → 1; SLTU → 0.
  - SRA with a=0x80000000, shamt=4 → 0xF8000000; SRL with the same inputs → 0x08000000.
- MULTU 0xFFFFFFFF × 2 (WIDTH=32):
  - `o_ready`=0 for 32 cycles; an ADD request presented meanwhile is ignored.
  - `o_valid` arrives 32 cycles after accept with `o_result`=0xFFFFFFFE, `o_hi`=1.
  - A following ADD leaves `o_hi`=1.
- Illegal: func 0x3F → `o_valid`=1, `o_illegal`=1, `o_result`=0, `o_aluControl`=1110.
- Reset mid-MULTU: assert `i_rst` at iteration 10 → no `o_valid`, `o_hi`=0, `o_ready`=1 the cycle after release. Without `ALU_MULTU_EN`, func 0x19 is illegal in one cycle.
